// File: rtl/ir_pkg.sv
// Shared constants and helpers for the IR sensor conditioner.
package ir_pkg;

  // Default hold time: 1 ms at a 12 MHz system clock.
  localparam int unsigned IR_DEBOUNCE_DEF = 12000;
  // Default width of each rising-edge event counter.
  localparam int unsigned IR_CNT_W_DEF    = 8;

  // LED drive selection.
  typedef enum logic [0:0] {
    LedFollow = 1'b0,
    LedToggle = 1'b1
  } led_mode_e;

  // Ceiling log2, never less than 1, used to size the hold counter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v != 0) begin
      result++;
      v = v >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ir_channel.sv
// One IR sensor channel: polarity fix, 2-flop synchroniser, hold-time glitch
// filter, edge pulses, LED toggle flop and saturating rising-edge counter.
module ir_channel
  import ir_pkg::*;
#(
  parameter int unsigned DEBOUNCE = IR_DEBOUNCE_DEF,
  parameter int unsigned CNT_W    = IR_CNT_W_DEF,
  parameter bit          INV      = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             raw_i,
  input  logic             led_mode_i,
  input  logic             cnt_clr_i,
  output logic             filtered_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             led_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned      HoldW   = clog2(DEBOUNCE);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  if (DEBOUNCE < 2) begin : gen_bad_debounce
    $error("ir_channel: DEBOUNCE must be at least 2");
  end

  logic             raw_c;
  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             accept;
  logic             accept_rise;
  logic             toggle_q, toggle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, fall_q;

  // Active-low sensors are flipped before synchronisation.
  assign raw_c = raw_i ^ INV;

  // The differing level has persisted long enough; take it this edge.
  assign accept      = (s2_q != stable_q) && (hold_q == HoldMax);
  assign accept_rise = accept & s2_q;

  // Filter next state: any return to the stable level restarts the hold count.
  always_comb begin
    stable_d = stable_q;
    hold_d   = '0;
    if (s2_q != stable_q) begin
      if (accept) begin
        stable_d = s2_q;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  // Toggle follows rises regardless of LED mode so a mode switch is glitch-free.
  always_comb begin
    toggle_d = toggle_q ^ accept_rise;
  end

  // Counter next state: clear wins over a simultaneous rise; saturate at max.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (accept_rise && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // All channel state, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      hold_q   <= '0;
      toggle_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      s1_q     <= raw_c;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      hold_q   <= hold_d;
      toggle_q <= toggle_d;
      cnt_q    <= cnt_d;
      rise_q   <= accept_rise;
      fall_q   <= accept & ~s2_q;
    end
  end

  assign filtered_o = stable_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign count_o    = cnt_q;

  // LED output selection between filtered level and toggle state.
  always_comb begin
    led_o = (led_mode_i == LedToggle) ? toggle_q : stable_q;
  end

endmodule

// File: rtl/ir_sensor_filter.sv
// N-channel IR sensor conditioner: one ir_channel per sensor pin, with the
// per-channel event counters packed into a single output bus.
module ir_sensor_filter
  import ir_pkg::*;
#(
  parameter int unsigned     N_CH     = 2,
  parameter int unsigned     DEBOUNCE = IR_DEBOUNCE_DEF,
  parameter int unsigned     CNT_W    = IR_CNT_W_DEF,
  parameter logic [N_CH-1:0] INVERT   = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_CH-1:0]       ir_raw,
  input  logic                  led_mode,
  input  logic                  cnt_clr,
  output logic [N_CH-1:0]       filtered,
  output logic [N_CH-1:0]       rise,
  output logic [N_CH-1:0]       fall,
  output logic [N_CH-1:0]       led,
  output logic [N_CH*CNT_W-1:0] events
);

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    ir_channel #(
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W),
      .INV      (INVERT[i])
    ) u_ch (
      .clk_i      (clk),
      .rst_ni     (rstn),
      .raw_i      (ir_raw[i]),
      .led_mode_i (led_mode),
      .cnt_clr_i  (cnt_clr),
      .filtered_o (filtered[i]),
      .rise_o     (rise[i]),
      .fall_o     (fall[i]),
      .led_o      (led[i]),
      .count_o    (events[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_ir_sensor_filter.sv
// Scoreboard bench for ir_sensor_filter with DEBOUNCE=4, CNT_W=3, N_CH=2.
module tb_ir_sensor_filter;

  localparam int unsigned NCH = 2;
  localparam int unsigned DEB = 4;
  localparam int unsigned CW  = 3;
  localparam int          LAT = DEB + 2;

  logic           clk = 1'b0;
  logic           rstn, led_mode, cnt_clr;
  logic [1:0]     ir_raw;
  logic [1:0]     filtered, rise, fall, led;
  logic [5:0]     events;

  logic           rstn2;
  logic [1:0]     ir_raw2;
  logic [1:0]     filtered2, rise2, fall2, led2;
  logic [5:0]     events2;

  ir_sensor_filter #(.N_CH(NCH), .DEBOUNCE(DEB), .CNT_W(CW), .INVERT(2'b00)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .ir_raw   (ir_raw),
    .led_mode (led_mode),
    .cnt_clr  (cnt_clr),
    .filtered (filtered),
    .rise     (rise),
    .fall     (fall),
    .led      (led),
    .events   (events)
  );

  ir_sensor_filter #(.N_CH(NCH), .DEBOUNCE(DEB), .CNT_W(CW), .INVERT(2'b10)) dut_inv (
    .clk      (clk),
    .rstn     (rstn2),
    .ir_raw   (ir_raw2),
    .led_mode (1'b0),
    .cnt_clr  (1'b0),
    .filtered (filtered2),
    .rise     (rise2),
    .fall     (fall2),
    .led      (led2),
    .events   (events2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         at;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] filt;
    logic [1:0] led;
    logic [5:0] ev;
  } exp_t;

  exp_t sb[$];

  // Bench-side expectation state.
  logic [1:0] m_filt = 2'b00;
  logic [1:0] m_tog  = 2'b00;
  logic       m_mode = 1'b0;
  int         m_cnt[2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Queue the response expected at negedge 'at' for a level change on channel ch.
  task automatic push_edge(input int ch, input logic val, input int at, input bit clr);
    exp_t e;
    e.rise = 2'b00;
    e.fall = 2'b00;
    if (val) begin
      e.rise[ch] = 1'b1;
      m_tog[ch]  = ~m_tog[ch];
      if (clr) begin
        m_cnt[0] = 0;
        m_cnt[1] = 0;
      end else if (m_cnt[ch] < 7) begin
        m_cnt[ch]++;
      end
    end else begin
      e.fall[ch] = 1'b1;
    end
    m_filt[ch] = val;
    e.at   = at;
    e.filt = m_filt;
    e.led  = m_mode ? m_tog : m_filt;
    e.ev   = {3'(m_cnt[1]), 3'(m_cnt[0])};
    sb.push_back(e);
  endtask

  task automatic drive(input int ch, input logic val);
    ir_raw[ch] = val;
    push_edge(ch, val, cyc + LAT, 1'b0);
    repeat (8) tick();
  endtask

  // Monitor: every pulse on the main DUT must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if ((rise != 2'b00) || (fall != 2'b00)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {28'd0, rise, fall}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("edge_cycle", cyc, e.at);
        check("edge_rise", {30'd0, rise}, {30'd0, e.rise});
        check("edge_fall", {30'd0, fall}, {30'd0, e.fall});
        check("edge_filtered", {30'd0, filtered}, {30'd0, e.filt});
        check("edge_led", {30'd0, led}, {30'd0, e.led});
        check("edge_events", {26'd0, events}, {26'd0, e.ev});
      end
    end else if ((sb.size() > 0) && (sb[0].at < cyc)) begin
      e = sb.pop_front();
      check("missed_edge_cycle", cyc, e.at);
    end
  end

  initial begin
    rstn     = 1'b0;
    rstn2    = 1'b0;
    ir_raw   = 2'b00;
    ir_raw2  = 2'b00;
    led_mode = 1'b0;
    cnt_clr  = 1'b0;

    // Reset state.
    repeat (3) tick();
    check("reset_filtered", {30'd0, filtered}, 32'd0);
    check("reset_led", {30'd0, led}, 32'd0);
    check("reset_events", {26'd0, events}, 32'd0);
    check("reset_pulses", {28'd0, rise, fall}, 32'd0);

    // Idle with inputs low.
    rstn = 1'b1;
    repeat (20) tick();
    check("idle_filtered", {30'd0, filtered}, 32'd0);
    check("idle_led", {30'd0, led}, 32'd0);
    check("idle_events", {26'd0, events}, 32'd0);

    // Channel 0 rises and holds.
    drive(0, 1'b1);
    check("ch0_count_one", {29'd0, events[2:0]}, 32'd1);
    check("ch1_unchanged", {31'd0, filtered[1]}, 32'd0);

    // Back low, then a 3-cycle glitch that must be rejected.
    drive(0, 1'b0);
    ir_raw[0] = 1'b1;
    repeat (3) tick();
    ir_raw[0] = 1'b0;
    repeat (10) tick();
    check("glitch3_filtered", {30'd0, filtered}, 32'd0);
    check("glitch3_count", {29'd0, events[2:0]}, 32'd1);

    // A 4-cycle pulse is long enough to be accepted, then falls again.
    ir_raw[0] = 1'b1;
    push_edge(0, 1'b1, cyc + LAT, 1'b0);
    repeat (4) tick();
    ir_raw[0] = 1'b0;
    push_edge(0, 1'b0, cyc + LAT, 1'b0);
    repeat (8) tick();
    check("glitch4_count", {29'd0, events[2:0]}, 32'd2);

    // Toggle mode on channel 1: led[1] goes 1,0,1 on the three rises.
    led_mode = 1'b1;
    m_mode   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1);
      drive(1, 1'b0);
    end
    check("toggle_led", {30'd0, led}, {30'd0, m_tog});
    led_mode = 1'b0;
    m_mode   = 1'b0;
    tick();
    check("follow_after_switch", {30'd0, led}, {30'd0, m_filt});

    // Nine rises on channel 0 saturate its 3-bit counter.
    for (int i = 0; i < 9; i++) begin
      drive(0, 1'b1);
      drive(0, 1'b0);
    end
    check("ch0_saturated", {29'd0, events[2:0]}, 32'd7);

    // Clear coincides with a rise: clear wins.
    ir_raw[0] = 1'b1;
    push_edge(0, 1'b1, cyc + LAT, 1'b1);
    repeat (LAT - 1) tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    repeat (4) tick();
    check("clear_beats_rise", {26'd0, events}, 32'd0);

    // Inverted channel 1 held low from reset is accepted as high.
    rstn2 = 1'b1;
    repeat (LAT - 1) tick();
    check("inv_not_yet", {30'd0, filtered2}, 32'd0);
    tick();
    check("inv_filtered", {30'd0, filtered2}, 32'd2);
    check("inv_rise", {30'd0, rise2}, 32'd2);
    check("inv_count", {29'd0, events2[5:3]}, 32'd1);
    check("inv_led", {30'd0, led2}, 32'd2);
    tick();
    check("inv_rise_one_cycle", {30'd0, rise2}, 32'd0);

    // Asynchronous reset mid-count clears everything without a clock edge.
    ir_raw2[0] = 1'b1;
    repeat (3) tick();
    #2;
    rstn2 = 1'b0;
    #1;
    check("async_rst_filtered", {30'd0, filtered2}, 32'd0);
    check("async_rst_led", {30'd0, led2}, 32'd0);
    check("async_rst_events", {26'd0, events2}, 32'd0);
    check("async_rst_pulses", {28'd0, rise2, fall2}, 32'd0);

    repeat (4) tick();
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
